// File: rtl/spi_target_regs.sv
// Mode-0 SPI target over an oversampled byte-addressed register bank; SPI_TGT_AUTOINC_EN enables address auto-increment.
// Pin-to-action latency is 3 clk_i cycles; there is no backpressure, so the host keeps SCK at or below clk_i/12.
module spi_target_regs #(
  parameter int         NumRegs = 16,
  parameter logic [7:0] IdVal   = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 spi_sck_i,
  input  logic                 spi_csb_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic                 spi_miso_en_o,
  output logic [NumRegs*8-1:0] regs_o,
  output logic                 reg_wr_o,
  output logic [6:0]           reg_wr_addr_o,
  output logic                 busy_o
);

  localparam int         AW       = $clog2(NumRegs);
  localparam logic [7:0] NumRegsW = 8'(NumRegs);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  logic [1:0] sck_sync, csb_sync, mosi_sync;
  logic       sck_prev, csb_prev;
  logic       sck_rise, sck_fall, csb_fall, csb_hi, mosi_bit;

  state_t     state_q;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] tx_q;
  logic       tx_vld;
  logic [7:0] rd_val;
  logic       in_range;
  logic [7:0] regs_q [NumRegs];

  // CSB stages reset low so a CSB still held low across reset is not taken as a new frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync  <= 2'b00;
      csb_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
      csb_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck_i};
      csb_sync  <= {csb_sync[0], spi_csb_i};
      mosi_sync <= {mosi_sync[0], spi_mosi_i};
      sck_prev  <= sck_sync[1];
      csb_prev  <= csb_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign sck_fall = ~sck_sync[1] & sck_prev;
  assign csb_fall = csb_prev & ~csb_sync[1];
  assign csb_hi   = csb_sync[1];
  assign mosi_bit = mosi_sync[1];
  assign rx_byte  = {rx_shift, mosi_bit};

  assign in_range = (addr_q != 7'd0) && ({1'b0, addr_q} < NumRegsW);

  always_comb begin
    rd_val = 8'h00;
    if (addr_q == 7'd0) begin
      rd_val = IdVal;
    end else if (in_range) begin
      rd_val = regs_q[addr_q[AW-1:0]];
    end
  end

  // CSB high has priority over everything, including a coincident 8th SCK rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      bit_cnt       <= 3'd0;
      rx_shift      <= 7'd0;
      rw_q          <= 1'b0;
      addr_q        <= 7'd0;
      tx_q          <= 8'h00;
      tx_vld        <= 1'b0;
      reg_wr_o      <= 1'b0;
      reg_wr_addr_o <= 7'd0;
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      reg_wr_o <= 1'b0;
      if (csb_hi) begin
        state_q  <= ST_IDLE;
        bit_cnt  <= 3'd0;
        rx_shift <= 7'd0;
        tx_q     <= 8'h00;
        tx_vld   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csb_fall) begin
              state_q <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw_q    <= rx_byte[7];
                addr_q  <= rx_byte[6:0];
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sck_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!rw_q && in_range) begin
                  regs_q[addr_q[AW-1:0]] <= rx_byte;
                  reg_wr_o               <= 1'b1;
                  reg_wr_addr_o          <= addr_q;
                end
`ifdef SPI_TGT_AUTOINC_EN
                addr_q <= addr_q + 7'd1;
`else
                addr_q <= addr_q;
`endif
              end
            end else if (sck_fall && rw_q) begin
              // The fall after a byte's last rise presents the first bit of the next byte.
              if (bit_cnt == 3'd0) begin
                tx_q   <= rd_val;
                tx_vld <= 1'b1;
              end else begin
                tx_q <= {tx_q[6:0], 1'b0};
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NumRegs; g++) begin : g_regs_out
    assign regs_o[8*g +: 8] = regs_q[g];
  end

  assign spi_miso_o    = tx_q[7];
  assign spi_miso_en_o = tx_vld;
  assign busy_o        = (state_q != ST_IDLE);

endmodule
